// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        VALID = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, issues single-outstanding IMEM requests
// and presents the fetched word (or an all-zero bubble) to the decode register.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         STALL_F,
    input  logic         REDIRECT_E,
    input  logic [31:0]  REDIRECT_ADDR_E,
    output logic         IMEM_REQ,
    output logic [31:0]  IMEM_ADDR,
    input  logic         IMEM_RVALID,
    input  logic [31:0]  IMEM_RDATA,
    output logic [31:0]  instr_F,
    output logic [31:0]  curr_instr_addr_F,
    output logic [31:0]  pc_plus4_F,
    output logic         FETCH_VALID_F,
    output fetch_state_t dbg_state,
    output logic         dbg_kill
);

    fetch_state_t state, state_n;
    logic [31:0]  pc, pc_n;
    logic [31:0]  ibuf, ibuf_n;
    logic         kill, kill_n;
    logic [31:0]  pc_inc;

    // Modulo-2^32 increment: 0xFFFF_FFFC wraps to 0, low bits pass through.
    assign pc_inc = pc + PC_STEP;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= FETCH;
            pc    <= RESET_PC;
            ibuf  <= NOP_INSTR;
            kill  <= 1'b0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            ibuf  <= ibuf_n;
            kill  <= kill_n;
        end
    end

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        ibuf_n    = ibuf;
        kill_n    = kill;
        IMEM_REQ  = 1'b0;
        IMEM_ADDR = pc;
        unique case (state)
            FETCH: begin
                IMEM_REQ = !REDIRECT_E;
                if (REDIRECT_E) pc_n = REDIRECT_ADDR_E;
                else            state_n = WAIT;
            end
            WAIT: begin
                if (IMEM_RVALID) begin
                    if (REDIRECT_E) begin
                        pc_n    = REDIRECT_ADDR_E;
                        kill_n  = 1'b0;
                        state_n = FETCH;
                    end else if (kill) begin
                        kill_n  = 1'b0;
                        state_n = FETCH;
                    end else begin
                        ibuf_n  = IMEM_RDATA;
                        state_n = VALID;
                    end
                end else if (REDIRECT_E) begin
                    // Response still in flight for the old PC: mark it for discard.
                    pc_n   = REDIRECT_ADDR_E;
                    kill_n = 1'b1;
                end
            end
            VALID: begin
                if (REDIRECT_E) begin
                    pc_n    = REDIRECT_ADDR_E;
                    state_n = FETCH;
                end else if (!STALL_F) begin
                    IMEM_REQ  = 1'b1;
                    IMEM_ADDR = pc_inc;
                    pc_n      = pc_inc;
                    state_n   = WAIT;
                end
            end
            default: state_n = FETCH;
        endcase
    end

    // Registered-only decode of the decode-side outputs; zero is the bubble.
    assign FETCH_VALID_F     = (state == VALID);
    assign instr_F           = FETCH_VALID_F ? ibuf   : NOP_INSTR;
    assign curr_instr_addr_F = FETCH_VALID_F ? pc     : 32'h0;
    assign pc_plus4_F        = FETCH_VALID_F ? pc_inc : 32'h0;

    assign dbg_state = state;
    assign dbg_kill  = kill;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, stall, redirects, kill, wrap and reset.
`timescale 1ns/1ps
module tb_fetch_unit;
    import fetch_pkg::*;

    logic         CLK;
    logic         RST;
    logic         STALL_F;
    logic         REDIRECT_E;
    logic [31:0]  REDIRECT_ADDR_E;
    logic         IMEM_RVALID;
    logic [31:0]  IMEM_RDATA;

    logic         req_a, req_w;
    logic [31:0]  addr_a, addr_w;
    logic [31:0]  instr_a, instr_w;
    logic [31:0]  cur_a, cur_w;
    logic [31:0]  pc4_a, pc4_w;
    logic         vld_a, vld_w;
    fetch_state_t st_a, st_w;
    logic         kill_a, kill_w;

    int compared = 0;
    int mismatched = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .CLK(CLK), .RST(RST), .STALL_F(STALL_F), .REDIRECT_E(REDIRECT_E),
        .REDIRECT_ADDR_E(REDIRECT_ADDR_E), .IMEM_REQ(req_a), .IMEM_ADDR(addr_a),
        .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA), .instr_F(instr_a),
        .curr_instr_addr_F(cur_a), .pc_plus4_F(pc4_a), .FETCH_VALID_F(vld_a),
        .dbg_state(st_a), .dbg_kill(kill_a)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .CLK(CLK), .RST(RST), .STALL_F(STALL_F), .REDIRECT_E(REDIRECT_E),
        .REDIRECT_ADDR_E(REDIRECT_ADDR_E), .IMEM_REQ(req_w), .IMEM_ADDR(addr_w),
        .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA), .instr_F(instr_w),
        .curr_instr_addr_F(cur_w), .pc_plus4_F(pc4_w), .FETCH_VALID_F(vld_w),
        .dbg_state(st_w), .dbg_kill(kill_w)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] instr,
                           input logic [31:0] cur, input logic [31:0] pc4, input logic vld);
        chk({tag, ".instr"}, instr_a, instr);
        chk({tag, ".addr"},  cur_a,   cur);
        chk({tag, ".pc4"},   pc4_a,   pc4);
        chk({tag, ".valid"}, {31'd0, vld_a}, {31'd0, vld});
    endtask

    task automatic chk_req(input string tag, input logic req, input logic [31:0] addr);
        #1;
        chk({tag, ".req"}, {31'd0, req_a}, {31'd0, req});
        if (req) chk({tag, ".req_addr"}, addr_a, addr);
    endtask

    initial begin
        RST = 1'b1; STALL_F = 1'b0; REDIRECT_E = 1'b0; REDIRECT_ADDR_E = 32'h0;
        IMEM_RVALID = 1'b0; IMEM_RDATA = 32'h0;
        tick();
        tick();

        // Reset state
        chk_out("reset", 32'h0, 32'h0, 32'h0, 1'b0);
        chk("reset.imem_addr", addr_a, 32'h0);
        chk("reset.state", {30'd0, st_a}, {30'd0, FETCH});
        RST = 1'b0;
        chk_req("seq0", 1'b1, 32'h0);

        // Sequential fetch with zero-wait memory: 0, 4, 8, 12, 0x10
        for (int i = 0; i < 5; i++) begin
            logic [31:0] a;
            a = 32'(i) * 32'd4;
            tick();
            IMEM_RVALID = 1'b1;
            IMEM_RDATA  = (a == 32'h10) ? 32'h2008_0005 : word(a);
            chk_req("seq.wait", 1'b0, 32'h0);
            chk_out("seq.wait", 32'h0, 32'h0, 32'h0, 1'b0);
            tick();
            IMEM_RVALID = 1'b0;
            if (a == 32'h10) STALL_F = 1'b1;
            chk_out("seq.valid", (a == 32'h10) ? 32'h2008_0005 : word(a), a, a + 32'd4, 1'b1);
            if (a != 32'h10) chk_req("seq.next", 1'b1, a + 32'd4);
        end

        // Stall for 3 cycles holding the instruction at 0x10
        for (int i = 0; i < 3; i++) begin
            chk_req("stall", 1'b0, 32'h0);
            chk_out("stall", 32'h2008_0005, 32'h10, 32'h14, 1'b1);
            tick();
        end
        STALL_F = 1'b0;
        chk_out("stall.rel", 32'h2008_0005, 32'h10, 32'h14, 1'b1);
        chk_req("stall.rel", 1'b1, 32'h14);
        tick();
        IMEM_RVALID = 1'b1; IMEM_RDATA = word(32'h14);
        tick();
        IMEM_RVALID = 1'b0;
        chk_out("v14", word(32'h14), 32'h14, 32'h18, 1'b1);

        // Redirect in VALID wins over a coincident stall
        REDIRECT_E = 1'b1; REDIRECT_ADDR_E = 32'h400; STALL_F = 1'b1;
        chk_req("rdv", 1'b0, 32'h0);
        tick();
        REDIRECT_E = 1'b0; STALL_F = 1'b0;
        chk("rdv.state", {30'd0, st_a}, {30'd0, FETCH});
        chk_out("rdv", 32'h0, 32'h0, 32'h0, 1'b0);
        chk_req("rdv.next", 1'b1, 32'h400);
        tick();

        // Redirect during WAIT, 3-cycle memory latency
        REDIRECT_E = 1'b1; REDIRECT_ADDR_E = 32'h80;
        chk_req("rdw", 1'b0, 32'h0);
        tick();
        REDIRECT_E = 1'b0;
        chk("rdw.kill", {31'd0, kill_a}, 32'd1);
        chk("rdw.state", {30'd0, st_a}, {30'd0, WAIT});
        chk_out("rdw.c1", 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        chk_out("rdw.c2", 32'h0, 32'h0, 32'h0, 1'b0);
        IMEM_RVALID = 1'b1; IMEM_RDATA = word(32'h400);
        chk_req("rdw.c3", 1'b0, 32'h0);
        tick();
        IMEM_RVALID = 1'b0;
        chk("rdw.kill_clr", {31'd0, kill_a}, 32'd0);
        chk("rdw.state_f", {30'd0, st_a}, {30'd0, FETCH});
        chk_out("rdw.drop", 32'h0, 32'h0, 32'h0, 1'b0);
        chk_req("rdw.new", 1'b1, 32'h80);
        tick();
        IMEM_RVALID = 1'b1; IMEM_RDATA = word(32'h80);
        tick();
        IMEM_RVALID = 1'b0;
        chk_out("v80", word(32'h80), 32'h80, 32'h84, 1'b1);

        // Simultaneous response and redirect in WAIT
        chk_req("sim.adv", 1'b1, 32'h84);
        tick();
        IMEM_RVALID = 1'b1; IMEM_RDATA = word(32'h84);
        REDIRECT_E = 1'b1; REDIRECT_ADDR_E = 32'h200;
        tick();
        IMEM_RVALID = 1'b0; REDIRECT_E = 1'b0;
        chk("sim.state", {30'd0, st_a}, {30'd0, FETCH});
        chk("sim.kill", {31'd0, kill_a}, 32'd0);
        chk_out("sim.drop", 32'h0, 32'h0, 32'h0, 1'b0);
        chk_req("sim.next", 1'b1, 32'h200);
        tick();
        IMEM_RVALID = 1'b1; IMEM_RDATA = word(32'h200);
        tick();
        IMEM_RVALID = 1'b0;
        chk_out("v200", word(32'h200), 32'h200, 32'h204, 1'b1);

        // Mid-run reset in VALID, then wrap on the second instance
        RST = 1'b1;
        tick();
        chk_out("rstv", 32'h0, 32'h0, 32'h0, 1'b0);
        chk("rstv.imem_addr", addr_a, 32'h0);
        chk("wrap.rst_addr", addr_w, 32'hFFFF_FFFC);
        chk("wrap.rst_valid", {31'd0, vld_w}, 32'd0);
        RST = 1'b0;
        #1;
        chk("wrap.req0", {31'd0, req_w}, 32'd1);
        chk("wrap.addr0", addr_w, 32'hFFFF_FFFC);
        tick();
        IMEM_RVALID = 1'b1; IMEM_RDATA = 32'h1234_5678;
        tick();
        IMEM_RVALID = 1'b0;
        #1;
        chk("wrap.valid", {31'd0, vld_w}, 32'd1);
        chk("wrap.instr", instr_w, 32'h1234_5678);
        chk("wrap.cur", cur_w, 32'hFFFF_FFFC);
        chk("wrap.pc4", pc4_w, 32'h0);
        chk("wrap.req1", {31'd0, req_w}, 32'd1);
        chk("wrap.addr1", addr_w, 32'h0);

        // Reset while the wrap instance is in VALID
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("wrst.valid", {31'd0, vld_w}, 32'd0);
        chk("wrst.instr", instr_w, 32'h0);
        chk("wrst.cur", cur_w, 32'h0);
        chk("wrst.pc4", pc4_w, 32'h0);
        chk("wrst.addr", addr_w, 32'hFFFF_FFFC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

- Instruction-fetch stage; the writer side of the Fetch→Decode pipeline register.
- Holds the PC and issues single-outstanding requests to the instruction memory. It presents `instr_F`, `curr_instr_addr_F` and `pc_plus4_F` to the decode register.
- Honours stall from the hazard unit and redirect from execute.
- When no valid instruction is available, the outputs are all-zero, which is the bubble (NOP) encoding the decode register also uses on clear.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `STALL_F` in 1: hold the current instruction and PC.
- `REDIRECT_E` in 1: branch/jump taken in execute.
- `REDIRECT_ADDR_E` in 32: target address for the redirect.
- `IMEM_REQ` out 1: one-cycle request pulse; the memory always accepts it.
- `IMEM_ADDR` out 32: request address; valid when `IMEM_REQ`=1.
- `IMEM_RVALID` in 1: response valid, 1 or more cycles after the request.
- `IMEM_RDATA` in 32: response instruction word.
- `instr_F` out 32: fetched instruction; 0 when invalid.
- `curr_instr_addr_F` out 32: address of `instr_F`; 0 when invalid.
- `pc_plus4_F` out 32: `curr_instr_addr_F`+4; 0 when invalid.
- `FETCH_VALID_F` out 1: outputs hold a real instruction.

## Operation
- **Registers:** `pc`, `ibuf` (32), `kill` (1), `state` ∈ {FETCH, WAIT, VALID}.
- **Reset:** `state`=FETCH, `pc`=`RESET_PC`, `ibuf`=0, `kill`=0. All outputs read 0 in the cycle after reset.
- **FETCH state:**
  - `IMEM_REQ`=!`REDIRECT_E`, `IMEM_ADDR`=`pc`.
  - If `REDIRECT_E`: `pc`←`REDIRECT_ADDR_E`, stay in FETCH, no request.
  - Otherwise go to WAIT.
  - `STALL_F` is ignored here, because there is no instruction to hold.
- **WAIT state:**
  - `IMEM_REQ`=0.
  - `IMEM_RVALID` with `kill`=0 and no `REDIRECT_E`: `ibuf`←`IMEM_RDATA`, go to VALID.
  - `IMEM_RVALID` with `kill`=1: discard the data, `kill`←0, go to FETCH.
  - `IMEM_RVALID` and `REDIRECT_E` in the same cycle: discard the data, `pc`←`REDIRECT_ADDR_E`, `kill`←0, go to FETCH.
  - `REDIRECT_E` without `IMEM_RVALID`: `pc`←`REDIRECT_ADDR_E`, `kill`←1, stay in WAIT. A repeated redirect updates `pc` only.
- **VALID state:**
  - Outputs: `instr_F`=`ibuf`, `curr_instr_addr_F`=`pc`, `pc_plus4_F`=`pc`+4, `FETCH_VALID_F`=1.
  - Priority: `REDIRECT_E`, then `STALL_F`, then advance.
  - `REDIRECT_E`: `pc`←`REDIRECT_ADDR_E`, no request, go to FETCH. The current instruction is dropped by the execute-side flush.
  - `STALL_F`: hold all state, no request.
  - Advance: `IMEM_REQ`=1, `IMEM_ADDR`=`pc`+4, `pc`←`pc`+4, go to WAIT.
- **Priority rule:** redirect wins over stall in every state.
- **Arithmetic:** `pc`+4 is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0. No alignment check is made; the low 2 bits pass through unchanged.
- `IMEM_RVALID` in the FETCH or VALID state is a protocol error and is ignored.
- **Reset during WAIT:** the memory is reset by the same `RST`, so no stale response follows reset. The bench must not drive one.

## Timing
- `IMEM_REQ`/`IMEM_ADDR` are combinational from `state`, `pc`, `STALL_F` and `REDIRECT_E`. All other outputs are decoded from registers only.
- **Zero-wait memory** (`IMEM_RVALID` the cycle after the request):
  - First instruction is valid 2 cycles after reset deasserts.
  - Steady-state throughput is 1 instruction per 2 cycles (VALID, WAIT).
- **Redirect latency:** with zero-wait memory, the target instruction is valid 3 cycles after the `REDIRECT_E` edge (FETCH, WAIT, VALID). A killed in-flight response adds its remaining latency.
- **Decode side:** the decode register samples the fetch outputs on the same edge at which the fetch unit advances. Zero outputs in non-VALID cycles insert bubbles into decode.

## Structure
- Package `fetch_pkg` holds:
  - the `fetch_state_t` enum (FETCH, WAIT, VALID);
  - `NOP_INSTR` = 32'h0;
  - `PC_STEP` = 32'd4.
- Single module with no sub-modules. The FSM and the PC datapath are small enough to stay flat.

## Test plan
- **Reset and sequential fetch:** `RST` then release; zero-wait memory returns addr-derived words. Required:
  - `IMEM_ADDR` sequence 0, 4, 8.
  - `FETCH_VALID_F` pulses every 2nd cycle.
  - `pc_plus4_F`=4, 8, 12.
- **Stall:** assert `STALL_F` for 3 cycles while `instr_F`=32'h2008_0005 at 0x10. Required:
  - outputs stable;
  - no `IMEM_REQ`;
  - on release, the request goes to 0x14.
- **Redirect in VALID:** `REDIRECT_E`=1, target 0x400, coincident with `STALL_F`=1. Required:
  - next state FETCH;
  - `FETCH_VALID_F`=0;
  - the next request goes to 0x400.
- **Redirect during WAIT with 3-cycle memory latency:** redirect to 0x80 one cycle after the request. Required:
  - the response for the old address is discarded;
  - a new request to 0x80 follows;
  - `instr_F` never shows the stale word.
- **Simultaneous `IMEM_RVALID` and `REDIRECT_E`:** required:
  - data dropped;
  - `kill` stays 0;
  - the next request goes to the redirect target.
- **Wrap and mid-run reset:**
  - `RESET_PC`=32'hFFFF_FFFC: the second request address is 0.
  - Assert `RST` in VALID: the next cycle all outputs are 0 and `IMEM_ADDR`=`RESET_PC`.
